// File: rtl/chirp_pkg.sv
// Shared definitions for the linear-chirp phase-increment generator:
// sweep mode encodings, FSM state type and the default increment width.
package chirp_pkg;

    localparam int DEFAULT_PHI_W = 32;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_CONT   = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_RSVD   = 2'd3
    } sweep_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/chirp_phase_fanout.sv
// Per-channel offset registers and registered base+offset adders: turns one
// sweeping base increment into NUM_CH evenly spaced NCO phase increments.
module chirp_phase_fanout
    import chirp_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int PHI_W  = DEFAULT_PHI_W
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [PHI_W-1:0]        ch_spacing,
    input  logic [PHI_W-1:0]        base,
    output logic [NUM_CH*PHI_W-1:0] phi_inc
);

    logic [PHI_W-1:0] offset [NUM_CH];

    // NOTE: the offset array is reset as well: the adders run every cycle,
    // so stale offsets would leak onto phi_inc while the generator is idle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                offset[k] <= '0;
            end
            phi_inc <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (load) begin
                    offset[k] <= ch_spacing * PHI_W'(k);
                end
                phi_inc[k*PHI_W +: PHI_W] <= base + offset[k];
            end
        end
    end

endmodule

// File: rtl/chirp_sweep_gen.sv
// Multi-channel linear-chirp generator: sweep FSM, dwell counter, base
// register and status pulses; the per-channel fan-out lives in a sub-module.
module chirp_sweep_gen
    import chirp_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int PHI_W   = DEFAULT_PHI_W,
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic [1:0]              mode_i,
    input  logic [PHI_W-1:0]        start_freq_i,
    input  logic [PHI_W-1:0]        stop_freq_i,
    input  logic [PHI_W-1:0]        step_i,
    input  logic [PHI_W-1:0]        ch_spacing_i,
    input  logic [DWELL_W-1:0]      dwell_i,
    output logic [NUM_CH*PHI_W-1:0] phi_inc_o,
    output logic                    phi_valid_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    wrap_o,
    output logic                    cfg_err_o,
    output logic [CNT_W-1:0]        sweep_cnt_o
);

    sweep_state_t     state, state_nxt;
    sweep_mode_t      cfg_mode, mode_in;
    logic [PHI_W-1:0] cfg_start, cfg_stop, cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;

    logic [PHI_W-1:0]   base, base_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
    logic [CNT_W-1:0]   sweep_cnt, cnt_nxt;
    logic               load_pend, load_nxt;
    logic               valid_q, valid_nxt;
    logic               done_q, done_nxt;
    logic               wrap_q, wrap_nxt;
    logic               err_q, err_nxt;
    logic               latch, cnt_inc, cfg_bad, dwell_hit;

    logic [PHI_W:0] up_sum, dn_diff;

    assign mode_in   = sweep_mode_t'(mode_i);
    assign cfg_bad   = (start_freq_i > stop_freq_i)
                    || (mode_in == MODE_RSVD)
                    || (mode_in == MODE_TRI && step_i > stop_freq_i - start_freq_i);
    assign dwell_hit = (dwell_cnt == cfg_dwell);

    // One extra bit turns an overflow into "above stop" and an underflow into a borrow flag.
    assign up_sum  = {1'b0, base} + {1'b0, cfg_step};
    assign dn_diff = {1'b0, base} - {1'b0, cfg_step};

    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        dwell_nxt = dwell_cnt;
        cnt_nxt   = sweep_cnt;
        load_nxt  = 1'b0;
        done_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        err_nxt   = start_i && !stop_i && cfg_bad;
        latch     = 1'b0;
        cnt_inc   = 1'b0;
        valid_nxt = (state != IDLE) && !load_pend;

        if (stop_i) begin
            state_nxt = IDLE;
        end else if (start_i && !cfg_bad) begin
            latch     = 1'b1;
            state_nxt = UP;
            dwell_nxt = '0;
            cnt_nxt   = '0;
            load_nxt  = 1'b1;
        end else if (load_pend) begin
            base_nxt = cfg_start;
        end else begin
            unique case (state)
                UP: begin
                    if (!dwell_hit) begin
                        dwell_nxt = dwell_cnt + DWELL_W'(1);
                    end else begin
                        dwell_nxt = '0;
                        if (up_sum <= {1'b0, cfg_stop}) begin
                            base_nxt = up_sum[PHI_W-1:0];
                        end else begin
                            case (cfg_mode)
                                MODE_SINGLE: begin
                                    done_nxt  = 1'b1;
                                    cnt_inc   = 1'b1;
                                    state_nxt = IDLE;
                                end
                                MODE_CONT: begin
                                    base_nxt = cfg_start;
                                    wrap_nxt = 1'b1;
                                    cnt_inc  = 1'b1;
                                end
                                MODE_TRI: begin
                                    base_nxt  = dn_diff[PHI_W-1:0];
                                    state_nxt = DOWN;
                                end
                                default: state_nxt = IDLE;
                            endcase
                        end
                    end
                end
                DOWN: begin
                    if (!dwell_hit) begin
                        dwell_nxt = dwell_cnt + DWELL_W'(1);
                    end else begin
                        dwell_nxt = '0;
                        if (!dn_diff[PHI_W] && dn_diff[PHI_W-1:0] >= cfg_start) begin
                            base_nxt = dn_diff[PHI_W-1:0];
                        end else begin
                            base_nxt  = up_sum[PHI_W-1:0];
                            state_nxt = UP;
                            wrap_nxt  = 1'b1;
                            cnt_inc   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (cnt_inc && sweep_cnt != '1) begin
            cnt_nxt = sweep_cnt + CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            dwell_cnt <= '0;
            sweep_cnt <= '0;
            load_pend <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            cfg_mode  <= MODE_SINGLE;
            cfg_start <= '0;
            cfg_stop  <= '0;
            cfg_step  <= '0;
            cfg_dwell <= '0;
        end else begin
            state     <= state_nxt;
            base      <= base_nxt;
            dwell_cnt <= dwell_nxt;
            sweep_cnt <= cnt_nxt;
            load_pend <= load_nxt;
            valid_q   <= valid_nxt;
            done_q    <= done_nxt;
            wrap_q    <= wrap_nxt;
            err_q     <= err_nxt;
            if (latch) begin
                cfg_mode  <= mode_in;
                cfg_start <= start_freq_i;
                cfg_stop  <= stop_freq_i;
                cfg_step  <= step_i;
                cfg_dwell <= dwell_i;
            end
        end
    end

    chirp_phase_fanout #(
        .NUM_CH (NUM_CH),
        .PHI_W  (PHI_W)
    ) u_fanout (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .load       (latch),
        .ch_spacing (ch_spacing_i),
        .base       (base),
        .phi_inc    (phi_inc_o)
    );

    assign busy_o      = (state != IDLE);
    assign phi_valid_o = valid_q;
    assign done_o      = done_q;
    assign wrap_o      = wrap_q;
    assign cfg_err_o   = err_q;
    assign sweep_cnt_o = sweep_cnt;

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// Scoreboard bench for chirp_sweep_gen (4 channels x 32 bits): stimulus queues
// expected phase vectors, a negedge monitor pops one per valid output cycle.
module tb_chirp_sweep_gen;
    import chirp_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int PHI_W   = 32;
    localparam int DWELL_W = 16;
    localparam int CNT_W   = 16;

    logic                    sys_clk = 1'b0;
    logic                    reset   = 1'b1;
    logic                    start_i = 1'b0;
    logic                    stop_i  = 1'b0;
    logic [1:0]              mode_i  = '0;
    logic [PHI_W-1:0]        start_freq_i = '0;
    logic [PHI_W-1:0]        stop_freq_i  = '0;
    logic [PHI_W-1:0]        step_i       = '0;
    logic [PHI_W-1:0]        ch_spacing_i = '0;
    logic [DWELL_W-1:0]      dwell_i      = '0;
    logic [NUM_CH*PHI_W-1:0] phi_inc_o;
    logic                    phi_valid_o, busy_o, done_o, wrap_o, cfg_err_o;
    logic [CNT_W-1:0]        sweep_cnt_o;

    always #5 sys_clk = ~sys_clk;

    chirp_sweep_gen #(
        .NUM_CH(NUM_CH), .PHI_W(PHI_W), .DWELL_W(DWELL_W), .CNT_W(CNT_W)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .mode_i       (mode_i),
        .start_freq_i (start_freq_i),
        .stop_freq_i  (stop_freq_i),
        .step_i       (step_i),
        .ch_spacing_i (ch_spacing_i),
        .dwell_i      (dwell_i),
        .phi_inc_o    (phi_inc_o),
        .phi_valid_o  (phi_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .wrap_o       (wrap_o),
        .cfg_err_o    (cfg_err_o),
        .sweep_cnt_o  (sweep_cnt_o)
    );

    typedef struct packed {
        logic [NUM_CH-1:0][PHI_W-1:0] phi;
        logic                         wrap;
        logic                         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_phi(input logic [NUM_CH*PHI_W-1:0] phi, input logic w, input logic d);
        exp_t e;
        e.phi  = phi;
        e.wrap = w;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Channel k = base + k*spacing; all spacings used here keep sums far below 2^32.
    task automatic push(input int unsigned b, input int unsigned sp, input logic w, input logic d);
        logic [NUM_CH*PHI_W-1:0] phi;
        for (int k = 0; k < NUM_CH; k++) begin
            phi[k*PHI_W +: PHI_W] = b + sp * k;
        end
        push_phi(phi, w, d);
    endtask

    task automatic cfg(input logic [1:0] m, input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] st, input logic [31:0] sp, input logic [15:0] dw);
        mode_i       = m;
        start_freq_i = s0;
        stop_freq_i  = s1;
        step_i       = st;
        ch_spacing_i = sp;
        dwell_i      = dw;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1;
        @(negedge sys_clk);
        stop_i = 1'b0;
    endtask

    // Monitor: one scoreboard entry per valid cycle; pulses outside valid cycles are errors.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (phi_valid_o) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: got phi=%h with empty queue", phi_inc_o);
                end else begin
                    e = exp_q.pop_front();
                    if (phi_inc_o !== e.phi || wrap_o !== e.wrap || done_o !== e.done) begin
                        n_fail++;
                        $display("FAIL scoreboard: got phi=%h wrap=%b done=%b, expected phi=%h wrap=%b done=%b",
                                 phi_inc_o, wrap_o, done_o, e.phi, e.wrap, e.done);
                    end
                end
            end else if (wrap_o || done_o) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_pulse: got wrap=%b done=%b with phi_valid_o=0, expected 0", wrap_o, done_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int unsigned tri_b [8] = '{1000, 1500, 2000, 2500, 2000, 1500, 1000, 1500};

    initial begin
        // Reset state
        wait_n(3);
        check("rst_phi", phi_inc_o, 0);
        check("rst_valid", phi_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_pulses", {done_o, wrap_o, cfg_err_o}, 0);
        check("rst_cnt", sweep_cnt_o, 0);
        reset = 1'b0;
        wait_n(1);

        // Single sweep 1000..2500, done on the last value
        cfg(2'd0, 1000, 2500, 500, 100, 0);
        for (int i = 0; i < 4; i++) push(1000 + 500 * i, 100, 1'b0, i == 3);
        pulse_start();
        check("m0_busy_t", busy_o, 1);
        check("m0_valid_t", phi_valid_o, 0);
        wait_n(1);
        check("m0_valid_t1", phi_valid_o, 0);
        wait_n(5);
        check("m0_busy_end", busy_o, 0);
        check("m0_cnt", sweep_cnt_o, 1);
        check("m0_drained", exp_q.size(), 0);

        // Continuous sawtooth: three periods, then stop
        cfg(2'd1, 1000, 2500, 500, 100, 0);
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++) push(1000 + 500 * i, 100, i == 3, 1'b0);
        push(1000, 100, 1'b0, 1'b0);
        pulse_start();
        wait_n(13);
        check("m1_cnt3", sweep_cnt_o, 3);
        pulse_stop();
        check("m1_busy_stop", busy_o, 0);
        wait_n(1);
        check("m1_valid_off", phi_valid_o, 0);
        check("m1_phi_hold", phi_inc_o[31:0], 1000);
        check("m1_cnt_hold", sweep_cnt_o, 3);

        // Triangle: up to 2500, back to 1000, turn around with wrap
        cfg(2'd2, 1000, 2500, 500, 100, 0);
        for (int i = 0; i < 8; i++) push(tri_b[i], 100, i == 6, 1'b0);
        pulse_start();
        wait_n(8);
        pulse_stop();
        wait_n(1);
        check("m2_valid_off", phi_valid_o, 0);
        check("m2_cnt", sweep_cnt_o, 1);

        // Dwell 2: each base value held for three cycles
        cfg(2'd1, 1000, 2500, 500, 100, 2);
        for (int i = 0; i < 4; i++)
            for (int r = 0; r < 3; r++) push(1000 + 500 * i, 100, (i == 3) && (r == 2), 1'b0);
        push(1000, 100, 1'b0, 1'b0);
        pulse_start();
        wait_n(13);
        pulse_stop();
        wait_n(1);
        check("dw_cnt", sweep_cnt_o, 1);

        // Carry out of the adder counts as exceeding stop; channel 1 wraps to 0
        cfg(2'd1, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 32'h100, 0);
        for (int i = 0; i < 5; i++)
            push_phi({32'h0000_0200, 32'h0000_0100, 32'h0000_0000, 32'hFFFF_FF00}, i < 4, 1'b0);
        pulse_start();
        wait_n(5);
        pulse_stop();
        wait_n(1);
        check("carry_cnt", sweep_cnt_o, 4);
        check("carry_valid_off", phi_valid_o, 0);

        // Rejected configurations
        cfg(2'd0, 3000, 2000, 500, 100, 0);
        pulse_start();
        check("err_order", cfg_err_o, 1);
        check("err_order_idle", busy_o, 0);
        wait_n(1);
        check("err_pulse_end", cfg_err_o, 0);
        cfg(2'd3, 1000, 2500, 500, 100, 0);
        pulse_start();
        check("err_mode3", cfg_err_o, 1);
        cfg(2'd2, 1000, 2500, 1501, 100, 0);
        pulse_start();
        check("err_tri_step", cfg_err_o, 1);
        check("err_tri_idle", busy_o, 0);
        cfg(2'd2, 1000, 2500, 1500, 100, 0);
        pulse_start();
        check("tri_step_edge_ok", {cfg_err_o, busy_o}, 2'b01);
        pulse_stop();
        check("tri_edge_stopped", busy_o, 0);
        wait_n(1);

        // start and stop together mid-sweep: stop wins
        cfg(2'd1, 1000, 2500, 500, 100, 0);
        for (int i = 0; i < 3; i++) push(1000 + 500 * i, 100, 1'b0, 1'b0);
        pulse_start();
        wait_n(3);
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge sys_clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("ss_busy", busy_o, 0);
        check("ss_no_err", cfg_err_o, 0);
        wait_n(2);
        check("ss_idle", {busy_o, phi_valid_o}, 0);

        // Reset mid-sweep, then a fresh single sweep
        for (int i = 0; i < 4; i++) push(1000 + 500 * i, 100, i == 3, 1'b0);
        push(1000, 100, 1'b0, 1'b0);
        pulse_start();
        wait_n(6);
        check("pre_rst_cnt", sweep_cnt_o, 1);
        reset = 1'b1;
        @(negedge sys_clk);
        check("mid_rst_phi", phi_inc_o, 0);
        check("mid_rst_flags", {phi_valid_o, busy_o, done_o, wrap_o, cfg_err_o}, 0);
        check("mid_rst_cnt", sweep_cnt_o, 0);
        reset = 1'b0;
        wait_n(1);
        cfg(2'd0, 1000, 2500, 500, 100, 0);
        for (int i = 0; i < 4; i++) push(1000 + 500 * i, 100, 1'b0, i == 3);
        pulse_start();
        wait_n(6);
        check("post_rst_cnt", sweep_cnt_o, 1);
        check("post_rst_busy", busy_o, 0);

        wait_n(2);
        check("final_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chirp_sweep_gen.md
Name: chirp_sweep_gen

Overview:
- Parametrised multi-channel linear-chirp phase-increment generator.
- Drives the phi_inc_i inputs of the NCO bank from sys_clk and replaces the simulation-only frequency ramp with synthesizable RTL.
- Produces NUM_CH phase increments per cycle, each offset from a common sweeping base by k*ch_spacing.
- Supports single-shot, continuous sawtooth and triangle (up/down) sweep modes, with a programmable dwell per step.

Parameters:
- NUM_CH, 16, number of output channels (NCO instances fed); must be >= 1.
- PHI_W, 32, phase-increment width; matches NCO phi_inc_i.
- DWELL_W, 16, width of the dwell counter.
- CNT_W, 16, width of the completed-sweep counter.

Ports:
- sys_clk  in  1  system clock. Single clock domain; no CDC inside.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse: latch config and begin a sweep.
- stop_i  in  1  one-cycle pulse: abort the sweep and go idle.
- mode_i  in  2  0 = single, 1 = continuous sawtooth, 2 = triangle, 3 = reserved (rejected).
- start_freq_i  in  PHI_W  base increment at sweep start.
- stop_freq_i  in  PHI_W  upper bound of base.
- step_i  in  PHI_W  base change per dwell period.
- ch_spacing_i  in  PHI_W  per-channel offset.
- dwell_i  in  DWELL_W  base held for dwell_i+1 cycles.
- phi_inc_o  out  NUM_CH*PHI_W  channel k occupies bits [k*PHI_W +: PHI_W].
- phi_valid_o  out  1  phi_inc_o is tracking an active sweep.
- busy_o  out  1  FSM not IDLE.
- done_o  out  1  one-cycle pulse: single sweep complete.
- wrap_o  out  1  one-cycle pulse: continuous or triangle period complete.
- cfg_err_o  out  1  one-cycle pulse: start rejected.
- sweep_cnt_o  out  CNT_W  completed periods; saturates at all-ones.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, base 0. Reset wins over every other input, including mid-sweep.
- Config latch and validation: on start_i, config is latched. start_i is rejected (cfg_err_o pulse, state unchanged) in any of these cases:
  - start_freq_i > stop_freq_i;
  - mode_i = 3;
  - mode 2 with step_i > stop_freq_i − start_freq_i.
- Valid start from any state (restart allowed): base <= start_freq, dwell counter cleared, sweep_cnt_o cleared, FSM to UP.
- Latency: start sampled at edge t gives base = start_freq at edge t+1. At edge t+2, phi_inc_o[k] = start_freq + k*ch_spacing (mod 2^PHI_W) and phi_valid_o = 1.
- Channel offsets: k*ch_spacing is computed once at latch time into offset registers. Output adders are registered, giving 1-cycle latency from base.
- Dwell: the dwell counter counts 0..dwell. Base updates only on the cycle the counter equals dwell, then the counter returns to 0. dwell = 0 updates base every cycle.
- State UP: next = base + step, computed in PHI_W+1 bits so a carry counts as exceeding stop.
  - next <= stop: base <= next.
  - next > stop, mode 0: done_o pulse, sweep_cnt_o++, FSM to IDLE, base holds its last value.
  - next > stop, mode 1: base <= start_freq, wrap_o pulse, sweep_cnt_o++.
  - next > stop, mode 2: base <= base − step, FSM to DOWN.
- State DOWN: next = base − step, with borrow detection.
  - next >= start: base <= next.
  - otherwise (next < start, or borrow): base <= base + step, FSM to UP, wrap_o pulse, sweep_cnt_o++.
- step = 0: base is constant and the sweep never terminates (static tone). This is legal.
- stop_i: FSM to IDLE next edge, phi_valid_o <= 0 on the following edge, phi_inc_o holds its last value. stop_i with start_i in the same cycle: stop wins and start is ignored. stop_i in IDLE: no effect.
- IDLE: phi_valid_o = 0. Inputs are ignored except start_i.
- Arithmetic: all values unsigned. Per-channel output wraps modulo 2^PHI_W.

Decomposition:
- Shared package chirp_pkg holds:
  - mode encodings (MODE_SINGLE, MODE_CONT, MODE_TRI);
  - FSM state typedef (IDLE, UP, DOWN);
  - default PHI_W.
- One sub-module, chirp_phase_fanout(NUM_CH, PHI_W):
  - offset registers, loaded on latch;
  - NUM_CH registered base+offset adders.
- The top holds the FSM, dwell counter, base register and status outputs.

Test Plan (NUM_CH=4, PHI_W=32):
- Reset asserted mid-sweep for 1 cycle → next edge: every output 0, busy_o = 0. A start issued afterwards behaves as from fresh reset.
- Mode 0, start=1000, step=500, stop=2500, spacing=100, dwell=0:
  - base sequence 1000, 1500, 2000, 2500; first valid ch3 = 1300, two cycles after start;
  - then done_o pulse, busy_o falls, sweep_cnt_o = 1.
- Mode 1, same config → base 1000..2500, then 1000 again; wrap_o pulses each period; sweep_cnt_o increments to 3 after three periods.
- Mode 2, same config → base 1000, 1500, 2000, 2500, 2000, 1500, 1000, 1500; wrap_o pulses on the 1000→1500 turnaround.
- dwell=2, mode 1 → each base value held exactly 3 cycles. Separately, start=0xFFFF_FF00, step=0x200, stop=0xFFFF_FFFF: the carry is treated as exceeding stop and base wraps to start.
- Error and abort cases:
  - start_freq=3000, stop=2000 → cfg_err_o pulse, state stays IDLE;
  - stop_i mid-sweep → phi_valid_o low 2 edges later;
  - start_i and stop_i in the same cycle → IDLE.
